// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD adder.
// Holds the controller state enum and the digit helpers.
package bcd_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   typedef logic [3:0] digit_t;

   localparam digit_t BCD_MAX  = 4'd9;
   localparam digit_t BCD_CORR = 4'd6;

   function automatic logic bad_digit(input digit_t d);
      return d > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal carry.
// Applies the +6 correction whenever the binary sum exceeds nine.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  digit_t x,
   input  digit_t y,
   input  logic   ci,
   output digit_t d,
   output logic   co
);

   logic [4:0] s;

   always_comb begin
      s  = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
      co = s > {1'b0, BCD_MAX};
      d  = co ? s[3:0] + BCD_CORR : s[3:0];
   end

endmodule

// File: rtl/bcd_seq_adder.sv
// Multi-digit BCD adder: one shared digit adder, LSD first,
// decimal carry rippled through a register.
module bcd_seq_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] sum,
   output logic                cout,
   output logic                err
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   state_t          state, state_n;
   logic [IW-1:0]   idx, idx_n;
   logic            carry, carry_n;
   logic [W-1:0]    opa, opa_n;
   logic [W-1:0]    opb, opb_n;
   logic [W-1:0]    sum_n;
   logic            cout_n, err_n, done_n;
   logic            any_bad;

   digit_t          dx, dy, dd;
   logic            dco;

   assign dx   = opa[idx*4 +: 4];
   assign dy   = opb[idx*4 +: 4];
   assign busy = (state == RUN);

   bcd_digit_add u_add (
      .x  (dx),
      .y  (dy),
      .ci (carry),
      .d  (dd),
      .co (dco)
   );

   always_comb begin
      any_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         any_bad = any_bad
                 | bad_digit(a[4*i +: 4])
                 | bad_digit(b[4*i +: 4]);
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      carry_n = carry;
      opa_n   = opa;
      opb_n   = opb;
      sum_n   = sum;
      cout_n  = cout;
      err_n   = err;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               opa_n   = a;
               opb_n   = b;
               sum_n   = '0;
               carry_n = 1'b0;
               cout_n  = 1'b0;
               idx_n   = '0;
               err_n   = any_bad;
               state_n = RUN;
            end
         end
         RUN: begin
            sum_n[idx*4 +: 4] = dd;
            carry_n = dco;
            if (idx == LAST) begin
               cout_n  = dco;
               done_n  = 1'b1;
               idx_n   = '0;
               state_n = IDLE;
            end else begin
               idx_n = idx + 1'b1;
            end
         end
      endcase
   end

   // Reset also discards captured operands so an aborted op leaves no trace.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         carry <= 1'b0;
         opa   <= '0;
         opb   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         err   <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         carry <= carry_n;
         opa   <= opa_n;
         opb   <= opb_n;
         sum   <= sum_n;
         cout  <= cout_n;
         err   <= err_n;
         done  <= done_n;
      end
   end

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Scoreboard bench for bcd_seq_adder: decimal reference model,
// directed cases then randomized traffic with resets.
module tb_bcd_seq_adder;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, cout, err;
   logic [W-1:0] sum;

   always #5 clk = ~clk;

   bcd_seq_adder #(.DIGITS(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         err;
      int           due;
      int           gen;
   } exp_t;

   exp_t q[$];
   exp_t cur, held, got_e;
   int   checks = 0, failures = 0;
   int   cyc = 0, gen = 0, left = 0;
   bit   m_busy = 0, m_done = 0, ready = 0;
   bit   end_req = 0, fin = 0;

   function automatic exp_t ref_add(input logic [W-1:0] x,
                                    input logic [W-1:0] y);
      exp_t   e;
      longint va = 0, vb = 0, t, p = 1;
      int     c = 0, s;
      e.err = 0;
      e.due = 0;
      e.gen = 0;
      for (int i = 0; i < D; i++)
         if (x[4*i +: 4] > 9 || y[4*i +: 4] > 9) e.err = 1;
      if (!e.err) begin
         for (int i = D - 1; i >= 0; i--) begin
            va = va * 10 + x[4*i +: 4];
            vb = vb * 10 + y[4*i +: 4];
         end
         for (int i = 0; i < D; i++) p = p * 10;
         t = va + vb;
         e.cout = (t >= p);
         if (e.cout) t = t - p;
         for (int i = 0; i < D; i++) begin
            e.sum[4*i +: 4] = 4'(t % 10);
            t = t / 10;
         end
      end else begin
         // invalid digits still follow the per-digit +6 rule
         for (int i = 0; i < D; i++) begin
            s = x[4*i +: 4] + y[4*i +: 4] + c;
            if (s > 9) begin
               s = s + 6;
               c = 1;
            end else begin
               c = 0;
            end
            e.sum[4*i +: 4] = 4'(s % 16);
         end
         e.cout = (c != 0);
      end
      return e;
   endfunction

   task automatic chk(input string name,
                      input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, got, exp, cyc);
      end
   endtask

   // Reference model: tracks accepted starts at each edge.
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         ready  = 1;
         m_busy = 0;
         m_done = 0;
         left   = 0;
         gen++;
         held   = '{default: 0};
         cur    = held;
      end else begin
         m_done = 0;
         if (m_busy) begin
            left--;
            if (left == 0) begin
               m_busy = 0;
               m_done = 1;
               held   = cur;
            end
         end else if (start) begin
            cur     = ref_add(a, b);
            cur.due = cyc + D;
            cur.gen = gen;
            q.push_back(cur);
            m_busy  = 1;
            left    = D;
         end
      end
   end

   // Monitor: compares DUT outputs on the falling edge.
   always @(negedge clk) begin
      if (end_req && !fin) begin
         int live = 0;
         foreach (q[i]) if (q[i].gen == gen) live++;
         chk("pending_ops", W'(live), '0);
         fin = 1;
      end else if (ready && !fin) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         if (done === 1'b1) begin
            while (q.size() > 0 && q[0].gen != gen)
               void'(q.pop_front());
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL done_unexpected: got done=1 expected no op (cycle %0d)",
                        cyc);
            end else begin
               got_e = q.pop_front();
               chk("sum", sum, got_e.sum);
               chk("cout", cout, got_e.cout);
               chk("err_done", err, got_e.err);
               checks++;
               if (cyc != got_e.due) begin
                  failures++;
                  $display("FAIL latency: got done at %0d expected %0d",
                           cyc, got_e.due);
               end
            end
         end
         if (m_busy) begin
            chk("err_run", err, cur.err);
         end else begin
            chk("sum_hold", sum, held.sum);
            chk("cout_hold", cout, held.cout);
            chk("err_hold", err, held.err);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1;
      a     = x;
      b     = y;
      tick(1);
      start = 0;
      a     = W'($urandom);
      b     = W'($urandom);
      tick(D);
   endtask

   function automatic logic [W-1:0] rand_bcd(input bit inv);
      logic [W-1:0] v;
      int           k;
      for (int i = 0; i < D; i++)
         v[4*i +: 4] = 4'($urandom_range(0, 9));
      if (inv) begin
         k = $urandom_range(0, D - 1);
         v[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      return v;
   endfunction

   initial begin
      rst_n = 0;
      start = 0;
      a     = '0;
      b     = '0;
      tick(2);
      rst_n = 1;
      tick(1);

      op(16'h1234, 16'h5678);
      tick(2);
      op(16'h9999, 16'h0001);
      tick(1);
      op(16'h0999, 16'h0001);
      tick(2);

      // start held through RUN with operands changing
      start = 1;
      a     = 16'h1111;
      b     = 16'h2222;
      tick(1);
      repeat (3) begin
         a = W'($urandom);
         b = W'($urandom);
         tick(1);
      end
      start = 0;
      tick(3);

      op(16'h00A0, 16'h0000);
      tick(2);

      // reset sampled at E2 of an operation
      start = 1;
      a     = 16'h4321;
      b     = 16'h1111;
      tick(1);
      start = 0;
      tick(1);
      rst_n = 0;
      tick(1);
      rst_n = 1;
      tick(1);
      op(16'h2468, 16'h1357);
      op(16'h5000, 16'h5000);
      tick(2);

      repeat (60) begin
         int r;
         r     = $urandom_range(0, 11);
         start = 1;
         a     = rand_bcd(r == 1);
         b     = rand_bcd(r == 2);
         repeat ($urandom_range(1, 7)) begin
            tick(1);
            a = rand_bcd(0);
            b = rand_bcd(0);
         end
         start = 0;
         if (r == 0) begin
            tick($urandom_range(0, 3));
            rst_n = 0;
            tick(1);
            rst_n = 1;
         end
         tick($urandom_range(0, 3));
      end

      start = 0;
      tick(D + 3);
      end_req = 1;
      tick(3);
      if (!fin) begin
         checks++;
         failures++;
         $display("FAIL monitor_end: got fin=0 expected 1");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
